// File: rtl/decode_operand_stage.sv
// ---------------------------------------------------------------------------
// decode_operand_stage
//
// Purpose:
//   Decode / operand-fetch stage of the Harvard 5-instruction core.
//   - Accepts 32-bit instructions from fetch over a valid/ready handshake.
//   - Decodes the R-type (ADDU) and I-type (ADDIU) fields.
//   - Owns the 32x32 register file.
//   - Presents a registered operand bundle to the execute stage.
//   - Writeback commits every cycle, independent of the handshake. A
//     writeback in the accept cycle is forwarded into the captured operands.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   fetch handshake (in_ready is combinational)
//   instr                 instruction word from fetch
//   wb_en/wb_addr/wb_data writeback port (writes to $0 are dropped)
//   out_valid / out_ready execute handshake
//   op1, op2              rs value; rt value or sign-extended imm16
//   opcode, func_code     instr[31:26], instr[5:0] (func_code 0 for ADDIU)
//   dest_addr, dest_we    destination index and its write enable
//   illegal               instruction is neither ADDU nor ADDIU
// ---------------------------------------------------------------------------
module decode_operand_stage #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [5:0]        opcode,
    output logic [5:0]        func_code,
    output logic [4:0]        dest_addr,
    output logic              dest_we,
    output logic              illegal
);

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] FUNC_ADDU = 6'b100001;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              accept;
    logic              wb_write;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        dec_opcode;
    logic [5:0]        dec_func;
    logic              is_addu;
    logic              is_addiu;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] d_op2;
    logic [5:0]        d_func;
    logic [4:0]        d_dest;
    logic              d_we;
    logic              d_illegal;

    // A new instruction may enter whenever the output slot is empty or is
    // being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Writes to $0 are discarded here, so $0 stays zero in the array.
    // The same qualifier also gates forwarding.
    assign wb_write = wb_en && (wb_addr != 5'd0);

    assign rs         = instr[25:21];
    assign rt         = instr[20:16];
    assign rd         = instr[15:11];
    assign dec_opcode = instr[31:26];
    assign dec_func   = instr[5:0];
    assign is_addu    = (dec_opcode == OPC_RTYPE) && (dec_func == FUNC_ADDU);
    assign is_addiu   = (dec_opcode == OPC_ADDIU);
    assign imm_ext    = {{(DATA_W-16){instr[15]}}, instr[15:0]};

    // Operand read with same-cycle writeback bypass. $0 is forced to zero
    // explicitly so that it can never pick up forwarded data.
    always_comb begin
        rs_val = regs[rs];
        rt_val = regs[rt];
        if (rs == 5'd0) begin
            rs_val = '0;
        end else if (wb_write && (wb_addr == rs)) begin
            rs_val = wb_data;
        end
        if (rt == 5'd0) begin
            rt_val = '0;
        end else if (wb_write && (wb_addr == rt)) begin
            rt_val = wb_data;
        end
    end

    // Field selection. Any encoding other than ADDU or ADDIU is decoded
    // with the R-type layout and flagged as illegal, which suppresses the
    // register write.
    always_comb begin
        d_op2     = rt_val;
        d_dest    = rd;
        d_func    = dec_func;
        d_illegal = !(is_addu || is_addiu);
        if (is_addiu) begin
            d_op2  = imm_ext;
            d_dest = rt;
            d_func = 6'd0;
        end
        d_we = !d_illegal && (d_dest != 5'd0);
    end

    // Register file. Writeback commits every cycle regardless of stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Output bundle. It loads only on accept and holds during a stall.
    // Operands are not refreshed by later writebacks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            op1       <= '0;
            op2       <= '0;
            opcode    <= '0;
            func_code <= '0;
            dest_addr <= '0;
            dest_we   <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            op1       <= rs_val;
            op2       <= d_op2;
            opcode    <= dec_opcode;
            func_code <= d_func;
            dest_addr <= d_dest;
            dest_we   <= d_we;
            illegal   <= d_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/decode_operand_stage.md
Name: decode_operand_stage

Overview:
Decode/operand-fetch stage that sits directly upstream of the ALU in the Harvard 5-instruction core. It accepts 32-bit instructions from fetch over a valid/ready handshake and decodes the R-type and I-type fields. It owns the 32x32 register file and drives op1/op2/opcode/func_code/dest to the execute stage through a registered valid/ready output. It also takes the writeback port and forwards same-cycle writeback data into the operands.

Parameters:
NUM_REGS, 32, register count; index width is 5 bits, fixed.
DATA_W, 32, register and operand width.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents instr
in_ready  out  1  stage can accept instr this cycle
instr  in  32  instruction word
wb_en  in  1  writeback strobe
wb_addr  in  5  writeback register index
wb_data  in  32  writeback value
out_valid  out  1  output bundle valid
out_ready  in  1  execute accepts bundle
op1  out  32  rs value
op2  out  32  rt value (R-type) or sign-extended imm16 (I-type)
opcode  out  6  instr[31:26]
func_code  out  6  instr[5:0]; 0 for I-type
dest_addr  out  5  rd (R-type) or rt (I-type)
dest_we  out  1  instruction writes a register (dest_addr != 0 and legal)
illegal  out  1  instruction not ADDU/ADDIU

Behaviour:
- Reset (rst_n=0, async, takes effect immediately, not on a clock edge): all 32 registers cleared to 0. out_valid=0. op1=op2=0, opcode=func_code=0, dest_addr=0, dest_we=0, illegal=0. Any in-flight bundle is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept on the edge where in_valid && in_ready. The output registers load and out_valid goes to 1 on that edge; issue latency is 1 cycle.
  - If out_valid && out_ready && !(in_valid && in_ready), out_valid clears to 0.
  - While out_valid && !out_ready, all outputs hold stable and instr is not sampled.
  - Back-to-back accepts give full throughput.
- Decode:
  - rs=instr[25:21], rt=instr[20:16], rd=instr[15:11].
  - R-type: opcode 000000. Legal only when func=100001 (ADDU). op2=rt value, dest_addr=rd.
  - I-type: opcode 001001 (ADDIU). op2={{16{instr[15]}},instr[15:0]}, dest_addr=rt, func_code=0.
  - Any other encoding: illegal=1, dest_we=0, other fields still decoded as R-type.
- Register file: reads are combinational from rs/rt at the accept edge. $0 always reads 0. Writes occur on the clock edge when wb_en=1 and wb_addr!=0; writes to $0 are dropped.
- Forwarding: if wb_en && wb_addr!=0 && wb_addr==rs (or rt) in the accept cycle, the captured operand is wb_data, not the stale register value. Writeback is never blocked by a stall; it commits every cycle regardless of the handshake.
- Operands are captured at accept only. A writeback arriving while the bundle is stalled does not update the held op1/op2; execute resolves that hazard.
- Simultaneous accept and pop: the new bundle replaces the old one and out_valid stays 1.

Test Plan:
- Reset, then wb $5=0x0000_0010 and $6=0x0000_0020. Send ADDU rd=7 (instr 0x00A63821) -> next cycle out_valid=1, op1=0x10, op2=0x20, opcode=0, func_code=0x21, dest_addr=7, dest_we=1, illegal=0.
- ADDIU rt=8, rs=5, imm=0xFFFF (instr 0x24A8FFFF) -> op1=0x10, op2=0xFFFF_FFFF, dest_addr=8, func_code=0.
- Same-cycle wb $5=0xDEAD_BEEF while accepting 0x00A63821 -> op1=0xDEAD_BEEF.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged. Raise out_ready -> one bundle pops and the next is accepted on the same edge with out_valid staying 1.
- wb $0=0x1234, then read rs=0 -> op1=0. Instr 0x00000020 (ADD, unsupported) -> illegal=1, dest_we=0.
- Assert rst_n=0 mid-stall with out_valid=1 -> out_valid drops to 0 immediately (before the next clock edge), and $5 reads 0 after release.
